calculator_grid_pipe: RTL
=========================

Name: calculator_grid_pipe

Overview:
- Parametrised, pipelined successor of the combinational 3x3 calculator grid.
- Instantiates GRID_X*GRID_Y operation tiles. Tile k = y*GRID_X + x is selected when mode == k.
- Adds valid/ready handshakes on input and output, a 2-stage pipeline with full backpressure, an explicit error flag for unmatched modes, and a completed-transaction counter.
- Sits between the DPI/MPI command front end and the result collector.

Parameters:
- WIDTH, 64, operand/result width in bits (>= 8).
- GRID_X, 3, tile columns (>= 1).
- GRID_Y, 3, tile rows (>= 1).
- MODE_W, 4, mode field width; GRID_X*GRID_Y <= 2**MODE_W.
- CNT_W, 16, width of done counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept request.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- mode  input  MODE_W  tile index to select.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_result  output  WIDTH  selected tile result.
- out_err  output  1  mode matched no tile.
- done_count  output  CNT_W  count of output handshakes.

Behaviour:
- Reset is asynchronous on rst_n low. It clears s1_valid, s2_valid, out_result, out_err and done_count to 0. in_ready reads 1 once rst_n is high. Any in-flight transactions are discarded; none reappear after reset.
- Tile operation is op = k mod 9, computed on the stage-1 operands:
  - 0 a+b; 1 a-b; 2 a&b; 3 a|b; 4 a^b.
  - 5 a<<b[5:0]; 6 a>>b[5:0] (logical).
  - 7 low WIDTH bits of a*b.
  - 8 {WIDTH-1 zeros, a==b}.
  - All arithmetic is modulo 2**WIDTH; unsigned.
  - Shifts of >= WIDTH yield 0.
- Selection:
  - One-hot match per tile, with match = (mode == k).
  - If no tile matches (mode >= GRID_X*GRID_Y): result = 0 and err = 1.
  - If several tiles match (not reachable by construction), the highest index wins.
- Stage 1:
  - Registers a, b and mode on the input handshake (in_valid && in_ready).
  - s1_valid is set on handshake. It is cleared when stage 1 advances with no new input.
- Stage 2:
  - Registers the selected result and err into out_result and out_err when s1_valid && s1_adv.
  - s2_valid drives out_valid.
- Handshake:
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv (combinational from out_ready; no skid buffer).
- Latency:
  - 2 cycles from input handshake to out_valid with no stalls.
  - Throughput is 1 per cycle when out_ready is held 1.
- Stall:
  - While out_valid && !out_ready, out_result and out_err are held stable.
  - Stage 1 holds if full. in_ready = 0 when both stages are full.
- Simultaneous accept/emit: a full pipeline with out_ready=1 and in_valid=1 accepts, shifts and emits in the same cycle.
- done_count:
  - Increments by 1 on each out_valid && out_ready, including error results.
  - Wraps from 2**CNT_W-1 to 0.
- in_valid must stay high with stable data until accepted; the block does not check this.

Test Plan:
- Reset then mode=0, a=5, b=7, in_valid for 1 cycle, out_ready=1 -> out_valid at cycle +2 with out_result=12, out_err=0, done_count=1.
- Default 3x3 grid, back-to-back modes 1..8 with a=0xF0, b=0x0F -> results in order: 0xE1, 0x00, 0xFF, 0xFF, 0xF0<<15, 0xF0>>15=0, 0xE10, 0; one per cycle, done_count=8.
- mode=9 and mode=15 on the 3x3 grid -> out_result=0 and out_err=1 for each; done_count still increments.
- Hold out_ready=0 and drive 3 requests:
  - Only 2 are accepted (in_ready drops to 0), and the output holds the first result stable.
  - Release out_ready -> all 3 results emerge in order with no loss or duplication.
- Assert rst_n low mid-stream with both stages full -> out_valid=0 and done_count=0 immediately (asynchronously). After release there are no stale outputs, and a new request completes with latency 2.
- Parametrised instance WIDTH=16, GRID_X=4, GRID_Y=4, MODE_W=4, CNT_W=3:
  - mode=15 (op 6), a=0x8000, b=3 -> 0x1000.
  - mode=7 with a=0xFFFF, b=0xFFFF -> 0x0001.
  - 9 transactions -> done_count wraps to 1.

Source files
------------

// File: rtl/calculator_grid_pipe_if.sv
// calculator_grid_pipe_if
//   Request/response bundle for calculator_grid_pipe.
//   Request side : in_valid, in_ready, a, b, mode
//   Response side: out_valid, out_ready, out_result, out_err
//   Status       : done_count (completed output handshakes)
//   modport slave  - the calculator block itself
//   modport master - whoever issues requests and consumes results
interface calculator_grid_pipe_if #(
    parameter int WIDTH  = 64,
    parameter int MODE_W = 4,
    parameter int CNT_W  = 16
) ();
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  b;
    logic [MODE_W-1:0] mode;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out_result;
    logic              out_err;
    logic [CNT_W-1:0]  done_count;

    modport master (
        output in_valid, a, b, mode, out_ready,
        input  in_ready, out_valid, out_result, out_err, done_count
    );

    modport slave (
        input  in_valid, a, b, mode, out_ready,
        output in_ready, out_valid, out_result, out_err, done_count
    );
endinterface

// File: rtl/calculator_grid_pipe.sv
// calculator_grid_pipe
//   Two-stage pipelined grid of GRID_X*GRID_Y operation tiles. Tile k
//   (k = y*GRID_X + x) performs operation k mod 9 on the stage-1 operands
//   and is selected when mode == k. A mode that selects no tile yields
//   result 0 with out_err set.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   bus    - calculator_grid_pipe_if.slave: request (in_valid/in_ready,
//            a, b, mode), response (out_valid/out_ready, out_result,
//            out_err) and done_count.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. Valid, once raised, stays high with stable payload until the
// transfer. in_ready is combinational from out_ready (no skid buffer), so a
// full pipeline with out_ready=1 accepts, shifts and emits in one cycle.
module calculator_grid_pipe #(
    parameter int WIDTH  = 64,
    parameter int GRID_X = 3,
    parameter int GRID_Y = 3,
    parameter int MODE_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    calculator_grid_pipe_if.slave bus
);
    localparam int NUM_TILES = GRID_X * GRID_Y;

    // Stage 1: captured request
    logic              s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0]  s1_a_q, s1_a_d;
    logic [WIDTH-1:0]  s1_b_q, s1_b_d;
    logic [MODE_W-1:0] s1_mode_q, s1_mode_d;

    // Stage 2: registered result
    logic              s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0]  out_result_q, out_result_d;
    logic              out_err_q, out_err_d;

    logic [CNT_W-1:0]  done_count_q, done_count_d;

    logic s1_adv, s2_adv, in_fire, out_fire;

    logic [WIDTH-1:0] tile_res [NUM_TILES];
    logic [WIDTH-1:0] sel_result;
    logic             sel_err;

    // Tile array: each tile's operation is fixed at elaboration time.
    for (genvar k = 0; k < NUM_TILES; k++) begin : g_tile
        localparam int OP = k % 9;
        if (OP == 0) begin : g_add
            assign tile_res[k] = s1_a_q + s1_b_q;
        end else if (OP == 1) begin : g_sub
            assign tile_res[k] = s1_a_q - s1_b_q;
        end else if (OP == 2) begin : g_and
            assign tile_res[k] = s1_a_q & s1_b_q;
        end else if (OP == 3) begin : g_or
            assign tile_res[k] = s1_a_q | s1_b_q;
        end else if (OP == 4) begin : g_xor
            assign tile_res[k] = s1_a_q ^ s1_b_q;
        end else if (OP == 5) begin : g_shl
            // A shift count of WIDTH or more naturally produces 0.
            assign tile_res[k] = s1_a_q << s1_b_q[5:0];
        end else if (OP == 6) begin : g_shr
            assign tile_res[k] = s1_a_q >> s1_b_q[5:0];
        end else if (OP == 7) begin : g_mul
            // Product is truncated to the low WIDTH bits by the assignment.
            assign tile_res[k] = s1_a_q * s1_b_q;
        end else begin : g_eq
            assign tile_res[k] = {{(WIDTH-1){1'b0}}, (s1_a_q == s1_b_q)};
        end
    end

    // One-hot selection; a later (higher) index overrides an earlier one.
    always_comb begin
        sel_result = '0;
        sel_err    = 1'b1;
        for (int k = 0; k < NUM_TILES; k++) begin
            if (s1_mode_q == MODE_W'(k)) begin
                sel_result = tile_res[k];
                sel_err    = 1'b0;
            end
        end
    end

    assign s2_adv   = !s2_valid_q || bus.out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_fire  = bus.in_valid && s1_adv;
    assign out_fire = s2_valid_q && bus.out_ready;

    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_a_d       = s1_a_q;
        s1_b_d       = s1_b_q;
        s1_mode_d    = s1_mode_q;
        s2_valid_d   = s2_valid_q;
        out_result_d = out_result_q;
        out_err_d    = out_err_q;
        done_count_d = done_count_q;

        if (s1_adv) begin
            s1_valid_d = in_fire;
        end
        if (in_fire) begin
            s1_a_d    = bus.a;
            s1_b_d    = bus.b;
            s1_mode_d = bus.mode;
        end

        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
        end
        if (s1_valid_q && s1_adv) begin
            out_result_d = sel_result;
            out_err_d    = sel_err;
        end

        if (out_fire) begin
            done_count_d = done_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            s1_a_q       <= '0;
            s1_b_q       <= '0;
            s1_mode_q    <= '0;
            s2_valid_q   <= 1'b0;
            out_result_q <= '0;
            out_err_q    <= 1'b0;
            done_count_q <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_a_q       <= s1_a_d;
            s1_b_q       <= s1_b_d;
            s1_mode_q    <= s1_mode_d;
            s2_valid_q   <= s2_valid_d;
            out_result_q <= out_result_d;
            out_err_q    <= out_err_d;
            done_count_q <= done_count_d;
        end
    end

    assign bus.in_ready   = s1_adv;
    assign bus.out_valid  = s2_valid_q;
    assign bus.out_result = out_result_q;
    assign bus.out_err    = out_err_q;
    assign bus.done_count = done_count_q;
endmodule
